time_set_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 21 ++
 rtl/time_set_ctrl_if.sv | 22 ++
 rtl/time_set_ctrl_btn_conditioner.sv | 47 ++++
 rtl/time_set_ctrl.sv | 129 ++++++++++++
 tb/tb_time_set_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Definitions shared by the time-setting controller and the timekeeping counter:
// FSM states, field-select codes and field ranges.
package clock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HH,
        ST_SET_MM,
        ST_SET_SS,
        ST_COMMIT
    } set_state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;
    localparam logic [1:0] FIELD_SECONDS = 2'b11;

    localparam logic [7:0] HOURS_MAX   = 8'd23;
    localparam logic [7:0] MIN_SEC_MAX = 8'd59;

endpackage

// File: rtl/time_set_ctrl_if.sv
// Load interface between the time-setting controller (master) and timekeeping (slave).
interface time_set_ctrl_if;

    logic       load_time;
    logic [7:0] load_hours;
    logic [7:0] load_minutes;
    logic [7:0] load_seconds;
    logic [7:0] cur_hours;
    logic [7:0] cur_minutes;
    logic [7:0] cur_seconds;

    modport master (
        output load_time, load_hours, load_minutes, load_seconds,
        input  cur_hours, cur_minutes, cur_seconds
    );

    modport slave (
        input  load_time, load_hours, load_minutes, load_seconds,
        output cur_hours, cur_minutes, cur_seconds
    );

endinterface

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, debounce filter and a one-cycle
// pulse on each accepted rising edge.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_p2;
    logic             level_p3;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            level_p2 <= 1'b0;
            level_p3 <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // Accept a new level only after it has differed for the full window;
            // any return to the accepted level restarts the count.
            if (sync_p1 == level_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_p2 <= sync_p1;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_p3 <= level_p2;
            press    <= level_p2 & ~level_p3;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Operator time-setting controller: button-driven hours/minutes/seconds editor
// that commits the edited time into the timekeeping counter.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int LOAD_HOLD_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            btn_dec,
    time_set_ctrl_if.master tk,
    output logic            set_active,
    output logic [1:0]      field_sel
);

    localparam int                HOLD_W    = $clog2(LOAD_HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOAD_HOLD_CYCLES - 1);

    set_state_t        state, state_nxt;
    logic [7:0]        edit_hours, edit_minutes, edit_seconds;
    logic [7:0]        hours_nxt, minutes_nxt, seconds_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              mode_press, inc_press, dec_press;
    logic              step_en, step_up;

    function automatic logic [7:0] wrap_step(input logic [7:0] value,
                                             input logic [7:0] max_value,
                                             input logic       up);
        logic [7:0] result;
        if (up) result = (value >= max_value) ? 8'd0 : value + 8'd1;
        else    result = (value == 8'd0) ? max_value : value - 8'd1;
        return result;
    endfunction

    function automatic logic [7:0] snap_field(input logic [7:0] value,
                                              input logic [7:0] max_value);
        return (value > max_value) ? 8'd0 : value;
    endfunction

    function automatic logic [1:0] field_of(input set_state_t s);
        logic [1:0] f;
        case (s)
            ST_SET_HH: f = FIELD_HOURS;
            ST_SET_MM: f = FIELD_MINUTES;
            ST_SET_SS: f = FIELD_SECONDS;
            default:   f = FIELD_NONE;
        endcase
        return f;
    endfunction

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .reset_n(reset_n), .btn(btn_mode), .press(mode_press));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .reset_n(reset_n), .btn(btn_inc), .press(inc_press));
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .clk(clk), .reset_n(reset_n), .btn(btn_dec), .press(dec_press));

    // Mode takes priority over edits; inc and dec together cancel out.
    always_comb begin
        state_nxt   = state;
        hours_nxt   = edit_hours;
        minutes_nxt = edit_minutes;
        seconds_nxt = edit_seconds;
        hold_nxt    = hold_cnt;
        step_en     = inc_press ^ dec_press;
        step_up     = inc_press;
        case (state)
            ST_IDLE: begin
                if (mode_press) begin
                    state_nxt   = ST_SET_HH;
                    hours_nxt   = snap_field(tk.cur_hours, HOURS_MAX);
                    minutes_nxt = snap_field(tk.cur_minutes, MIN_SEC_MAX);
                    seconds_nxt = snap_field(tk.cur_seconds, MIN_SEC_MAX);
                end
            end
            ST_SET_HH: begin
                if (mode_press)   state_nxt = ST_SET_MM;
                else if (step_en) hours_nxt = wrap_step(edit_hours, HOURS_MAX, step_up);
            end
            ST_SET_MM: begin
                if (mode_press)   state_nxt = ST_SET_SS;
                else if (step_en) minutes_nxt = wrap_step(edit_minutes, MIN_SEC_MAX, step_up);
            end
            ST_SET_SS: begin
                if (mode_press) begin
                    state_nxt = ST_COMMIT;
                    hold_nxt  = HOLD_LAST;
                end else if (step_en) begin
                    seconds_nxt = wrap_step(edit_seconds, MIN_SEC_MAX, step_up);
                end
            end
            ST_COMMIT: begin
                if (hold_cnt == '0) state_nxt = ST_IDLE;
                else                hold_nxt  = hold_cnt - 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            edit_hours   <= '0;
            edit_minutes <= '0;
            edit_seconds <= '0;
            hold_cnt     <= '0;
            tk.load_time <= 1'b0;
            set_active   <= 1'b0;
            field_sel    <= FIELD_NONE;
        end else begin
            state        <= state_nxt;
            edit_hours   <= hours_nxt;
            edit_minutes <= minutes_nxt;
            edit_seconds <= seconds_nxt;
            hold_cnt     <= hold_nxt;
            tk.load_time <= (state_nxt == ST_COMMIT);
            set_active   <= (state_nxt != ST_IDLE);
            field_sel    <= field_of(state_nxt);
        end
    end

    assign tk.load_hours   = edit_hours;
    assign tk.load_minutes = edit_minutes;
    assign tk.load_seconds = edit_seconds;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: event-level model of the operator editor checked every cycle,
// plus directed literal checks on latency, wrap, commit length and reset.
module tb_time_set_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int LAT  = 2 + DEB + 1 + 1;  // raw rise to visible FSM reaction

    localparam int M_IDLE = 0, M_HH = 1, M_MM = 2, M_SS = 3, M_COMMIT = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc  = 1'b0;
    logic       btn_dec  = 1'b0;
    logic       set_active;
    logic [1:0] field_sel;

    time_set_ctrl_if tk();

    time_set_ctrl #(.DEBOUNCE_CYCLES(DEB), .LOAD_HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .btn_dec(btn_dec), .tk(tk), .set_active(set_active), .field_sel(field_sel));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit check_en = 1'b0;

    // Press events keyed by the clock edge at which the FSM must react.
    bit ev_mode[int];
    bit ev_inc[int];
    bit ev_dec[int];

    int m_state = M_IDLE;
    int m_hold  = 0;
    int m_h = 0, m_m = 0, m_s = 0;

    int run = 0, last_run = 0;
    int cap_h = 0, cap_m = 0, cap_s = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = M_IDLE;
            m_hold  = 0;
            m_h = 0; m_m = 0; m_s = 0;
        end else begin
            bit m, i, d;
            int e, dir;
            e = cyc + 1;
            m = ev_mode.exists(e);
            i = ev_inc.exists(e);
            d = ev_dec.exists(e);
            dir = i ? 1 : -1;
            case (m_state)
                M_IDLE: if (m) begin
                    m_state = M_HH;
                    m_h = (tk.cur_hours   > 23) ? 0 : int'(tk.cur_hours);
                    m_m = (tk.cur_minutes > 59) ? 0 : int'(tk.cur_minutes);
                    m_s = (tk.cur_seconds > 59) ? 0 : int'(tk.cur_seconds);
                end
                M_HH, M_MM, M_SS: begin
                    if (m) begin
                        if (m_state == M_SS) begin
                            m_state = M_COMMIT;
                            m_hold  = HOLD;
                        end else begin
                            m_state = m_state + 1;
                        end
                    end else if (i != d) begin
                        if (m_state == M_HH)      m_h = (m_h + dir + 24) % 24;
                        else if (m_state == M_MM) m_m = (m_m + dir + 60) % 60;
                        else                      m_s = (m_s + dir + 60) % 60;
                    end
                end
                default: begin
                    m_hold = m_hold - 1;
                    if (m_hold == 0) m_state = M_IDLE;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("load_time",    tk.load_time,    (m_state == M_COMMIT) ? 1 : 0);
            chk("set_active",   set_active,      (m_state != M_IDLE) ? 1 : 0);
            chk("field_sel",    field_sel,       (m_state >= M_HH && m_state <= M_SS) ? m_state : 0);
            chk("load_hours",   tk.load_hours,   m_h);
            chk("load_minutes", tk.load_minutes, m_m);
            chk("load_seconds", tk.load_seconds, m_s);
        end
        if (tk.load_time === 1'b1) begin
            if (run == 0) begin
                cap_h = tk.load_hours;
                cap_m = tk.load_minutes;
                cap_s = tk.load_seconds;
            end
            run++;
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit m, input bit i, input bit d, input int hi, input int lo);
        int c;
        c = cyc;
        if (m) ev_mode[c + LAT] = 1'b1;
        if (i) ev_inc[c + LAT]  = 1'b1;
        if (d) ev_dec[c + LAT]  = 1'b1;
        btn_mode = m; btn_inc = i; btn_dec = d;
        tick(hi);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        tick(lo);
    endtask

    task automatic press(input bit m, input bit i, input bit d);
        pulse(m, i, d, 10, 10);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_load_time"},  tk.load_time,    0);
        chk({tag, "_set_active"}, set_active,      0);
        chk({tag, "_field_sel"},  field_sel,       0);
        chk({tag, "_hours"},      tk.load_hours,   0);
        chk({tag, "_minutes"},    tk.load_minutes, 0);
        chk({tag, "_seconds"},    tk.load_seconds, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, k;
        tk.cur_hours = 8'd12; tk.cur_minutes = 8'd34; tk.cur_seconds = 8'd56;
        tick(3);
        check_en = 1'b1;
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        tick(2);

        press(0, 1, 0);
        chk("idle_inc_set_active", set_active, 0);
        chk("idle_inc_hours", tk.load_hours, 0);

        // Full edit from 12:34:56 to 15:32:57.
        press(1, 0, 0);
        chk("snap_field", field_sel, 1);
        chk("snap_hours", tk.load_hours, 12);
        chk("snap_minutes", tk.load_minutes, 34);
        chk("snap_seconds", tk.load_seconds, 56);
        repeat (3) press(0, 1, 0);
        chk("edit_hours", tk.load_hours, 15);
        press(1, 0, 0);
        repeat (2) press(0, 0, 1);
        chk("edit_minutes", tk.load_minutes, 32);
        press(1, 0, 0);
        press(0, 1, 0);
        chk("edit_seconds", tk.load_seconds, 57);
        press(1, 0, 0);
        chk("commit_len", last_run, 8);
        chk("commit_hours", cap_h, 15);
        chk("commit_minutes", cap_m, 32);
        chk("commit_seconds", cap_s, 57);
        chk("after_commit_field", field_sel, 0);
        chk("after_commit_active", set_active, 0);

        // Wraps, bounce, mixed presses, mode during commit.
        tk.cur_hours = 8'd23; tk.cur_minutes = 8'd0; tk.cur_seconds = 8'd59;
        press(1, 0, 0);
        press(0, 1, 0);
        chk("wrap_hours_up", tk.load_hours, 0);
        for (int b = 0; b < 10; b++) begin
            btn_inc = (b % 2 == 0);
            tick(2);
        end
        c = cyc;
        ev_inc[c + LAT] = 1'b1;
        btn_inc = 1'b1;
        tick(LAT - 1);
        chk("bounce_before", tk.load_hours, 0);
        tick(1);
        chk("bounce_after", tk.load_hours, 1);
        btn_inc = 1'b0;
        tick(12);
        chk("bounce_single", tk.load_hours, 1);
        press(1, 0, 0);
        press(0, 0, 1);
        chk("wrap_minutes_down", tk.load_minutes, 59);
        press(1, 1, 0);
        chk("mode_inc_field", field_sel, 3);
        chk("mode_inc_minutes", tk.load_minutes, 59);
        press(0, 1, 0);
        chk("wrap_seconds_up", tk.load_seconds, 0);
        press(0, 1, 1);
        chk("inc_dec_same", tk.load_seconds, 0);
        pulse(1, 0, 0, 4, 4);
        press(1, 0, 0);
        chk("commit_mode_len", last_run, 8);
        chk("commit_mode_active", set_active, 0);
        chk("commit_mode_hours", cap_h, 1);

        // Out-of-range snapshot, then reset inside SET_MM.
        tk.cur_hours = 8'd30; tk.cur_minutes = 8'd7; tk.cur_seconds = 8'd8;
        press(1, 0, 0);
        chk("snap_hours_oor", tk.load_hours, 0);
        chk("snap_minutes_7", tk.load_minutes, 7);
        press(1, 0, 0);
        chk("in_set_mm", field_sel, 2);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mm");
        tick(2);
        reset_n = 1'b1;
        tick(2);

        // Reset in the middle of a commit.
        tk.cur_hours = 8'd1; tk.cur_minutes = 8'd2; tk.cur_seconds = 8'd3;
        repeat (3) press(1, 0, 0);
        pulse(1, 0, 0, 4, 0);
        k = 0;
        while (tk.load_time !== 1'b1 && k < 20) begin
            tick(1);
            k++;
        end
        chk("commit_rise_in_time", (k < 20) ? 1 : 0, 1);
        tick(3);
        chk("mid_commit_high", tk.load_time, 1);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_commit");
        tick(2);
        reset_n = 1'b1;
        tick(20);
        chk("post_reset_idle", set_active, 0);
        chk("post_reset_load", tk.load_time, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
